axi_burst_mem_slave: RTL and testbench

//  Parametrised AXI memory slave; successor to the first-generation bench slave.
//  - Independent write and read engines. Both run concurrently.
//  - Supports FIXED/INCR/WRAP bursts, narrow transfers, byte strobes and error responses.
//  - Sits behind the AXI master VIP as the DUT-side memory model and as a synthesizable scratch RAM.

---
 rtl/axi_burst_mem_slave_pkg.sv | 36 +++
 rtl/axi_burst_mem_slave_addr_gen.sv | 54 +++++
 rtl/axi_burst_mem_slave.sv | 275 +++++++++++++++++++++++++++
 tb/tb_axi_burst_mem_slave.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_burst_mem_slave_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_mem_slave_pkg
// Purpose  : Shared types and constants for the AXI burst memory slave:
//            burst encoding, response codes, FSM state encodings and the
//            WRAP length legality helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package axi_burst_mem_slave_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_e;

    localparam logic [1:0] c_resp_okay   = 2'b00;
    localparam logic [1:0] c_resp_slverr = 2'b10;

    // Write engine states
    localparam logic [1:0] c_w_idle = 2'd0;
    localparam logic [1:0] c_w_data = 2'd1;
    localparam logic [1:0] c_w_resp = 2'd2;

    // Read engine states
    localparam logic [0:0] c_r_idle = 1'b0;
    localparam logic [0:0] c_r_data = 1'b1;

    // WRAP is only legal for 2, 4, 8 or 16 beats; anything else behaves as INCR.
    function automatic logic wrap_len_ok(input logic [3:0] len);
        return (len == 4'd1) || (len == 4'd3) || (len == 4'd7) || (len == 4'd15);
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi_burst_mem_slave_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_mem_slave_addr_gen
// Purpose  : Combinational next-beat address generator for one AXI engine.
// Ports    : addr      in  ADDR_W  address of the current beat
//            size      in  3       log2 of bytes per beat
//            len       in  4       burst length minus one
//            burst     in  2       FIXED / INCR / WRAP
//            next_addr out ADDR_W  address of the following beat
//            size_err  out 1       beat size wider than the data bus
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_mem_slave_addr_gen
    import axi_burst_mem_slave_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic [2:0]        size,
    input  logic [3:0]        len,
    input  logic [1:0]        burst,
    output logic [ADDR_W-1:0] next_addr,
    output logic              size_err
);

    localparam int c_max_size = $clog2(DATA_W / 8);

    logic [ADDR_W-1:0] w_bytes;
    logic [ADDR_W-1:0] w_aligned;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;

    always_comb begin
        w_bytes   = ADDR_W'(1) << size;
        w_aligned = addr & ~(w_bytes - ADDR_W'(1));
        w_incr    = w_aligned + w_bytes;
        // Wrap container is (len+1)*bytes; a power of two when len is legal.
        w_mask    = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
        next_addr = w_incr;
        case (burst)
            FIXED:   next_addr = addr;
            WRAP: begin
                if (wrap_len_ok(len)) begin
                    next_addr = (addr & ~w_mask) | (w_incr & w_mask);
                end
            end
            default: next_addr = w_incr;
        endcase
        size_err = (size > 3'(c_max_size));
    end

endmodule
`default_nettype wire

// File: rtl/axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : axi_burst_mem_slave
// Purpose  : AXI memory slave with independent write and read engines,
//            FIXED/INCR/WRAP bursts, narrow transfers, byte strobes and
//            SLVERR responses for oversize beats and out-of-range addresses.
// Ports    : aclk/arst                 clock, async active-high reset
//            aw*/w*/b*                 write address, data, response channels
//            ar*/r*                    read address and data channels
// Revision : 1.0 - initial release
// ============================================================================
module axi_burst_mem_slave
    import axi_burst_mem_slave_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 16,
    parameter int ID_W      = 4,
    parameter int MEM_BYTES = 4096
) (
    input  logic                aclk,
    input  logic                arst,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [3:0]          awlen,
    input  logic [2:0]          awsize,
    input  logic [1:0]          awburst,
    input  logic                awvalid,
    output logic                awready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    input  logic                wvalid,
    output logic                wready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    output logic                bvalid,
    input  logic                bready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [3:0]          arlen,
    input  logic [2:0]          arsize,
    input  logic [1:0]          arburst,
    input  logic                arvalid,
    output logic                arready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast,
    output logic                rvalid,
    input  logic                rready
);

    localparam int c_strb_w = DATA_W / 8;
    localparam int c_idx_w  = $clog2(MEM_BYTES);

    logic [7:0] r_mem [MEM_BYTES];

    // Holds both address-ready outputs low while reset is asserted and for
    // the first edge after release.
    logic r_out_en;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) r_out_en <= 1'b0;
        else      r_out_en <= 1'b1;
    end

    // ------------------------------------------------------------------
    // Write engine
    // ------------------------------------------------------------------
    logic [1:0]        r_wstate;
    logic [ID_W-1:0]   r_awid;
    logic [ADDR_W-1:0] r_waddr;
    logic [3:0]        r_awlen;
    logic [2:0]        r_awsize;
    logic [1:0]        r_awburst;
    logic [3:0]        r_wcnt;
    logic              r_werr;

    logic [ADDR_W-1:0]  w_wnext;
    logic               w_wsize_err;
    logic               w_wbeat_err;
    logic               w_wbeat;
    logic [c_idx_w-1:0] w_widx;

    axi_burst_mem_slave_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_gen (
        .addr      (r_waddr),
        .size      (r_awsize),
        .len       (r_awlen),
        .burst     (r_awburst),
        .next_addr (w_wnext),
        .size_err  (w_wsize_err)
    );

    assign awready     = r_out_en && (r_wstate == c_w_idle);
    assign wready      = (r_wstate == c_w_data);
    assign bvalid      = (r_wstate == c_w_resp);
    assign bid         = r_awid;
    assign bresp       = r_werr ? c_resp_slverr : c_resp_okay;
    assign w_wbeat     = wvalid && wready;
    assign w_wbeat_err = w_wsize_err ||
                         ((ADDR_W+1)'(r_waddr) >= (ADDR_W+1)'(MEM_BYTES));
    // Strobes are lane-based, so bytes land relative to the bus-aligned word.
    assign w_widx      = c_idx_w'(r_waddr) & ~c_idx_w'(c_strb_w - 1);

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_wstate  <= c_w_idle;
            r_awid    <= '0;
            r_waddr   <= '0;
            r_awlen   <= '0;
            r_awsize  <= '0;
            r_awburst <= '0;
            r_wcnt    <= '0;
            r_werr    <= 1'b0;
        end else begin
            case (r_wstate)
                c_w_idle: begin
                    if (awvalid && awready) begin
                        r_awid    <= awid;
                        r_waddr   <= awaddr;
                        r_awlen   <= awlen;
                        r_awsize  <= awsize;
                        r_awburst <= awburst;
                        r_wcnt    <= '0;
                        r_werr    <= 1'b0;
                        r_wstate  <= c_w_data;
                    end
                end
                c_w_data: begin
                    if (w_wbeat) begin
                        r_werr  <= r_werr | w_wbeat_err;
                        r_waddr <= w_wnext;
                        r_wcnt  <= r_wcnt + 4'd1;
                        // Burst closes on whichever comes first: wlast or awlen.
                        if (wlast || (r_wcnt == r_awlen)) begin
                            r_wstate <= c_w_resp;
                        end
                    end
                end
                c_w_resp: begin
                    if (bready) r_wstate <= c_w_idle;
                end
                default: r_wstate <= c_w_idle;
            endcase
        end
    end

    // Backing store is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (w_wbeat && !w_wbeat_err) begin
            for (int i = 0; i < c_strb_w; i++) begin
                if (wstrb[i]) r_mem[w_widx + c_idx_w'(i)] <= wdata[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read engine
    // ------------------------------------------------------------------
    logic [0:0]        r_rstate;
    logic [ID_W-1:0]   r_arid;
    logic [ADDR_W-1:0] r_raddr;
    logic [3:0]        r_arlen;
    logic [2:0]        r_arsize;
    logic [1:0]        r_arburst;
    logic [3:0]        r_rcnt;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;
    logic              r_rlast;
    logic              r_rvalid;

    logic               w_ridle;
    logic [ADDR_W-1:0]  w_rg_addr;
    logic [2:0]         w_rg_size;
    logic [3:0]         w_rg_len;
    logic [1:0]         w_rg_burst;
    logic [ADDR_W-1:0]  w_rnext;
    logic               w_rsize_err;
    logic [ADDR_W-1:0]  w_rload_addr;
    logic               w_rload_err;
    logic [c_idx_w-1:0] w_ridx;
    logic [DATA_W-1:0]  w_rload_data;

    assign w_ridle = (r_rstate == c_r_idle);

    // In idle the generator sees the incoming AR so its size check applies
    // to the first beat; afterwards it steps the latched burst.
    assign w_rg_addr  = w_ridle ? araddr  : r_raddr;
    assign w_rg_size  = w_ridle ? arsize  : r_arsize;
    assign w_rg_len   = w_ridle ? arlen   : r_arlen;
    assign w_rg_burst = w_ridle ? arburst : r_arburst;

    axi_burst_mem_slave_addr_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_gen (
        .addr      (w_rg_addr),
        .size      (w_rg_size),
        .len       (w_rg_len),
        .burst     (w_rg_burst),
        .next_addr (w_rnext),
        .size_err  (w_rsize_err)
    );

    assign w_rload_addr = w_ridle ? araddr : w_rnext;
    assign w_rload_err  = w_rsize_err ||
                          ((ADDR_W+1)'(w_rload_addr) >= (ADDR_W+1)'(MEM_BYTES));

    // Sampled on the handshake edge, so a same-cycle write shows old data.
    always_comb begin
        w_ridx       = c_idx_w'(w_rload_addr) & ~c_idx_w'(c_strb_w - 1);
        w_rload_data = '0;
        if (!w_rload_err) begin
            for (int i = 0; i < c_strb_w; i++) begin
                w_rload_data[8*i +: 8] = r_mem[w_ridx + c_idx_w'(i)];
            end
        end
    end

    assign arready = r_out_en && w_ridle;
    assign rid     = r_arid;
    assign rdata   = r_rdata;
    assign rresp   = r_rresp;
    assign rlast   = r_rlast;
    assign rvalid  = r_rvalid;

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            r_rstate  <= c_r_idle;
            r_arid    <= '0;
            r_raddr   <= '0;
            r_arlen   <= '0;
            r_arsize  <= '0;
            r_arburst <= '0;
            r_rcnt    <= '0;
            r_rdata   <= '0;
            r_rresp   <= c_resp_okay;
            r_rlast   <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            case (r_rstate)
                c_r_idle: begin
                    if (arvalid && arready) begin
                        r_arid    <= arid;
                        r_raddr   <= araddr;
                        r_arlen   <= arlen;
                        r_arsize  <= arsize;
                        r_arburst <= arburst;
                        r_rcnt    <= '0;
                        r_rdata   <= w_rload_data;
                        r_rresp   <= w_rload_err ? c_resp_slverr : c_resp_okay;
                        r_rlast   <= (arlen == 4'd0);
                        r_rvalid  <= 1'b1;
                        r_rstate  <= c_r_data;
                    end
                end
                c_r_data: begin
                    if (rready) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rstate <= c_r_idle;
                        end else begin
                            r_raddr <= w_rnext;
                            r_rcnt  <= r_rcnt + 4'd1;
                            r_rdata <= w_rload_data;
                            r_rresp <= w_rload_err ? c_resp_slverr : c_resp_okay;
                            r_rlast <= ((r_rcnt + 4'd1) == r_arlen);
                        end
                    end
                end
                default: r_rstate <= c_r_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_burst_mem_slave
// Purpose  : Self-checking bench for axi_burst_mem_slave. A byte-array model
//            computes expected B and R responses from the burst rules; a
//            negedge monitor compares every handshake and stall cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_burst_mem_slave;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int ID_W   = 4;
    localparam int MEM_B  = 4096;

    logic        aclk = 1'b0;
    logic        arst = 1'b1;
    logic [3:0]  awid = '0;
    logic [15:0] awaddr = '0;
    logic [3:0]  awlen = '0;
    logic [2:0]  awsize = '0;
    logic [1:0]  awburst = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wlast = 1'b0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  arid = '0;
    logic [15:0] araddr = '0;
    logic [3:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready = 1'b1;

    axi_burst_mem_slave #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ID_W(ID_W), .MEM_BYTES(MEM_B)) dut (
        .aclk(aclk), .arst(arst),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    always #5 aclk = ~aclk;

    typedef struct packed {logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last;} rexp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

    rexp_t rq[$];
    bexp_t bq[$];
    logic [7:0]  mem_m [MEM_B];
    logic [31:0] wd [16];
    logic [3:0]  ws [16];
    logic [31:0] got_data [16];
    int          got_n = 0;
    logic [1:0]  last_bresp = 2'b00;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got event expected none/other", nm);
    endtask

    // Address of beat i from first principles (closed form, not iterative).
    function automatic int beat_addr(input int start, input int len, input int size, input int burst, input int i);
        int bytes, al, cont, base;
        bytes = 1 << size;
        al    = start - (start % bytes);
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            cont = (len + 1) * bytes;
            base = start - (start % cont);
            return base + ((al - base + i * bytes) % cont);
        end
        return al + i * bytes;
    endfunction

    function automatic bit model_wr(input int a, input int size, input logic [31:0] d, input logic [3:0] s);
        int b;
        if (size > 2 || a >= MEM_B) return 1'b1;
        b = a - (a % 4);
        for (int j = 0; j < 4; j++) if (s[j]) mem_m[b + j] = d[8*j +: 8];
        return 1'b0;
    endfunction

    function automatic rexp_t model_rd(input int a, input int size);
        rexp_t e;
        int b;
        e = '0;
        if (size > 2 || a >= MEM_B) begin
            e.resp = 2'b10;
        end else begin
            b = a - (a % 4);
            for (int j = 0; j < 4; j++) e.data[8*j +: 8] = mem_m[b + j];
        end
        return e;
    endfunction

    // ---------------- monitor / compare process ----------------
    bit          r_stall = 1'b0;
    bit          b_stall = 1'b0;
    logic [31:0] p_rdata;
    logic [3:0]  p_rid;
    logic [1:0]  p_rresp;
    logic        p_rlast;
    logic [3:0]  p_bid;
    logic [1:0]  p_bresp;

    always @(negedge aclk) begin
        rexp_t re;
        bexp_t be;
        if (arst) begin
            r_stall = 1'b0;
            b_stall = 1'b0;
        end else begin
            if (r_stall) begin
                chk("r_hold_valid", rvalid, 1'b1);
                chk("r_hold_data", rdata, p_rdata);
                chk("r_hold_ctl", {p_rid, p_rresp, p_rlast}, {rid, rresp, rlast});
            end
            r_stall = 1'b0;
            if (rvalid && rready) begin
                if (rq.size() == 0) fail("r_unexpected_beat");
                else begin
                    re = rq.pop_front();
                    chk("rid", rid, re.id);
                    chk("rdata", rdata, re.data);
                    chk("rresp", rresp, re.resp);
                    chk("rlast", rlast, re.last);
                    if (got_n < 16) got_data[got_n] = rdata;
                    got_n++;
                end
            end else if (rvalid) begin
                r_stall = 1'b1;
                p_rdata = rdata; p_rid = rid; p_rresp = rresp; p_rlast = rlast;
            end
            if (b_stall) begin
                chk("b_hold_valid", bvalid, 1'b1);
                chk("b_hold_payload", {bid, bresp}, {p_bid, p_bresp});
            end
            b_stall = 1'b0;
            if (bvalid && bready) begin
                if (bq.size() == 0) fail("b_unexpected_resp");
                else begin
                    be = bq.pop_front();
                    chk("bid", bid, be.id);
                    chk("bresp", bresp, be.resp);
                    last_bresp = bresp;
                end
            end else if (bvalid) begin
                b_stall = 1'b1;
                p_bid = bid; p_bresp = bresp;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_aw(input logic [3:0] id, input int addr, input int len, input int size, input int burst);
        awid = id; awaddr = 16'(addr); awlen = 4'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (awready) break;
        end
        if (!awready) fail("aw_timeout");
        @(posedge aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic send_beat(input int i, input bit last);
        wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = last;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (wready) break;
        end
        if (!wready) fail("w_timeout");
        @(posedge aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic write_burst(input logic [3:0] id, input int addr, input int len, input int size,
                               input int burst, input int nbeats, input bit last_flag);
        bit    err;
        bexp_t e;
        err = 1'b0;
        for (int i = 0; i < nbeats; i++)
            if (model_wr(beat_addr(addr, len, size, burst, i), size, wd[i], ws[i])) err = 1'b1;
        e.id = id; e.resp = err ? 2'b10 : 2'b00;
        bq.push_back(e);
        send_aw(id, addr, len, size, burst);
        for (int i = 0; i < nbeats; i++) send_beat(i, last_flag && (i == nbeats - 1));
        for (int k = 0; k < 300 && bq.size() != 0; k++) @(posedge aclk);
        if (bq.size() != 0) begin fail("b_timeout"); bq.delete(); end
        @(posedge aclk); #1;
    endtask

    task automatic read_burst(input logic [3:0] id, input int addr, input int len, input int size, input int burst);
        rexp_t e;
        for (int i = 0; i <= len; i++) begin
            e = model_rd(beat_addr(addr, len, size, burst, i), size);
            e.id = id; e.last = (i == len);
            rq.push_back(e);
        end
        arid = id; araddr = 16'(addr); arlen = 4'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (arready) break;
        end
        if (!arready) fail("ar_timeout");
        @(posedge aclk); #1;
        arvalid = 1'b0;
        for (int k = 0; k < 300 && rq.size() != 0; k++) @(posedge aclk);
        if (rq.size() != 0) begin fail("r_timeout"); rq.delete(); end
        @(posedge aclk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        // Reset state
        #12;
        chk("rst_ready", {awready, wready, arready}, 3'b000);
        chk("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
        chk("rst_ids", {bid, rid, bresp, rresp}, 12'h000);
        chk("rst_rdata", rdata, 32'h0);
        #10 arst = 1'b0;
        @(posedge aclk); #1;
        @(posedge aclk); #1;
        chk("post_rst_ready", {awready, wready, arready}, 3'b101);

        // Model pins for WRAP address sequence
        chk("wrap_a0", beat_addr(32'h38, 3, 2, 2, 0), 32'h38);
        chk("wrap_a1", beat_addr(32'h38, 3, 2, 2, 1), 32'h3C);
        chk("wrap_a2", beat_addr(32'h38, 3, 2, 2, 2), 32'h30);
        chk("wrap_a3", beat_addr(32'h38, 3, 2, 2, 3), 32'h34);

        // 1: INCR write then read back
        wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
        for (int i = 0; i < 16; i++) ws[i] = 4'hF;
        write_burst(4'hA, 32'h10, 3, 2, 1, 4, 1'b1);
        got_n = 0;
        read_burst(4'hA, 32'h10, 3, 2, 1);
        chk("t1_beats", got_n, 4);
        chk("t1_d0", got_data[0], 32'h11);
        chk("t1_d3", got_data[3], 32'h44);

        // 2: WRAP read
        wd[0] = 32'hC0DE0030; wd[1] = 32'hC0DE0034; wd[2] = 32'hC0DE0038; wd[3] = 32'hC0DE003C;
        write_burst(4'h3, 32'h30, 3, 2, 1, 4, 1'b1);
        got_n = 0;
        read_burst(4'h7, 32'h38, 3, 2, 2);
        chk("t2_d0", got_data[0], 32'hC0DE0038);
        chk("t2_d1", got_data[1], 32'hC0DE003C);
        chk("t2_d2", got_data[2], 32'hC0DE0030);
        chk("t2_d3", got_data[3], 32'hC0DE0034);

        // 3: narrow byte write
        wd[0] = 32'h11223344; ws[0] = 4'hF;
        write_burst(4'h1, 32'h0, 0, 2, 1, 1, 1'b1);
        wd[0] = 32'h00AB0000; ws[0] = 4'b0100;
        write_burst(4'h2, 32'h2, 0, 0, 1, 1, 1'b1);
        ws[0] = 4'hF;
        got_n = 0;
        read_burst(4'h2, 32'h0, 0, 2, 1);
        chk("t3_word", got_data[0], 32'h11AB3344);

        // 4: rready stall mid-burst, bready hold
        got_n = 0;
        fork
            read_burst(4'h5, 32'h10, 3, 2, 1);
            begin
                for (int k = 0; k < 100 && got_n < 2; k++) @(negedge aclk);
                @(posedge aclk); #1 rready = 1'b0;
                repeat (5) @(posedge aclk);
                #1 rready = 1'b1;
            end
        join
        chk("t4_beats", got_n, 4);
        chk("t4_d2", got_data[2], 32'h33);
        bready = 1'b0;
        wd[0] = 32'h0BAD0040;
        fork
            write_burst(4'h9, 32'h40, 0, 2, 1, 1, 1'b1);
            begin
                for (int k = 0; k < 50 && !bvalid; k++) @(negedge aclk);
                repeat (5) @(posedge aclk);
                @(negedge aclk);
                chk("t4_b_held", bvalid, 1'b1);
                @(posedge aclk); #1 bready = 1'b1;
            end
        join

        // 5: out of range and oversize
        wd[0] = 32'hDEADBEEF; wd[1] = 32'h12345678;
        write_burst(4'h4, MEM_B - 4, 1, 2, 1, 2, 1'b1);
        chk("t5_oob_bresp", last_bresp, 2'b10);
        got_n = 0;
        read_burst(4'h4, MEM_B - 4, 1, 2, 1);
        chk("t5_oob_d0", got_data[0], 32'hDEADBEEF);
        chk("t5_oob_d1", got_data[1], 32'h0);
        wd[0] = 32'hFFFFFFFF;
        write_burst(4'h6, 32'h10, 0, 3, 1, 1, 1'b1);
        chk("t5_size_bresp", last_bresp, 2'b10);
        got_n = 0;
        read_burst(4'h6, 32'h10, 0, 2, 1);
        chk("t5_unchanged", got_data[0], 32'h11);
        got_n = 0;
        read_burst(4'h6, 32'h10, 0, 3, 1);
        chk("t5_size_rd", got_data[0], 32'h0);
        // early wlast (2 of 4 beats) and missing wlast (ends at awlen)
        wd[0] = 32'hE0; wd[1] = 32'hE1; wd[2] = 32'hE2; wd[3] = 32'hE3;
        write_burst(4'h8, 32'h80, 3, 2, 1, 2, 1'b1);
        write_burst(4'h8, 32'h90, 1, 2, 1, 2, 1'b0);
        got_n = 0;
        read_burst(4'h8, 32'h90, 1, 2, 1);
        chk("t5_nolast_d1", got_data[1], 32'hE1);

        // 6: concurrent engines
        wd[0] = 32'h200; wd[1] = 32'h204; wd[2] = 32'h208; wd[3] = 32'h20C;
        write_burst(4'hB, 32'h200, 3, 2, 1, 4, 1'b1);
        wd[0] = 32'h100; wd[1] = 32'h104; wd[2] = 32'h108; wd[3] = 32'h10C;
        got_n = 0;
        fork
            write_burst(4'hC, 32'h100, 3, 2, 1, 4, 1'b1);
            read_burst(4'hD, 32'h200, 3, 2, 1);
        join
        chk("t6_rd_d3", got_data[3], 32'h20C);
        got_n = 0;
        read_burst(4'hC, 32'h100, 3, 2, 1);
        chk("t6_wr_d1", got_data[1], 32'h104);

        // 6b: reset in the middle of a write burst
        wd[0] = 32'h300; wd[1] = 32'h304; wd[2] = 32'h308; wd[3] = 32'h30C;
        void'(model_wr(32'h300, 2, wd[0], 4'hF));
        void'(model_wr(32'h304, 2, wd[1], 4'hF));
        send_aw(4'hE, 32'h300, 3, 2, 1);
        send_beat(0, 1'b0);
        send_beat(1, 1'b0);
        #2 arst = 1'b1;
        #1;
        chk("t6_rst_ready", {awready, wready, arready}, 3'b000);
        chk("t6_rst_valid", {bvalid, rvalid}, 2'b00);
        bq.delete(); rq.delete();
        repeat (2) @(posedge aclk);
        #3 arst = 1'b0;
        repeat (10) @(posedge aclk);
        #1;
        chk("t6_no_bvalid", bvalid, 1'b0);
        got_n = 0;
        read_burst(4'hE, 32'h300, 1, 2, 1);
        chk("t6_kept_d1", got_data[1], 32'h304);

        repeat (3) @(posedge aclk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
